// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcode, load-strobe, select and state definitions for the
// seq_ctrl_unit sequencer and its decoder.
// Optional feature macro: SEQ_CTRL_JC_EN (enables opcode 1010 = JC).
package ctrl_pkg;

    localparam int unsigned OPC_W = 4;
    localparam int unsigned NLD   = 4;

    // 4-bit TD4-class opcodes; unlisted codes decode as NOP
    typedef enum logic [OPC_W-1:0] {
        OP_ADD_A    = 4'b0000,
        OP_MOV_AB   = 4'b0001,
        OP_IN_A     = 4'b0010,
        OP_MOV_A_IM = 4'b0011,
        OP_MOV_BA   = 4'b0100,
        OP_ADD_B    = 4'b0101,
        OP_IN_B     = 4'b0110,
        OP_MOV_B_IM = 4'b0111,
        OP_HALT     = 4'b1000,
        OP_OUT_B    = 4'b1001,
        OP_JC       = 4'b1010,
        OP_OUT_IM   = 4'b1011,
        OP_JNC      = 4'b1110,
        OP_JMP      = 4'b1111
    } opcode_t;

    // Active-low one-hot load strobes: bit0=A, bit1=B, bit2=OUT, bit3=PC
    localparam logic [NLD-1:0] LOAD_A    = 4'b1110;
    localparam logic [NLD-1:0] LOAD_B    = 4'b1101;
    localparam logic [NLD-1:0] LOAD_OUT  = 4'b1011;
    localparam logic [NLD-1:0] LOAD_PC   = 4'b0111;
    localparam logic [NLD-1:0] LOAD_NONE = 4'b1111;

    typedef enum logic [1:0] {
        SEL_A    = 2'b00,
        SEL_B    = 2'b01,
        SEL_IN   = 2'b10,
        SEL_ZERO = 2'b11
    } sel_t;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'b00,
        ST_EXEC     = 2'b01,
        ST_OUT_WAIT = 2'b10,
        ST_HALTED   = 2'b11
    } state_t;

endpackage

// File: rtl/seq_ctrl_dec.sv
// seq_ctrl_dec: combinational opcode + carry -> load strobes / ALU select lookup.
// Ports: op (OP_W) opcode, c carry; ld_n (4) active-low loads, sel (2) ALU select,
//        is_out OUT-class instruction, is_halt HALT instruction.
// Optional feature macro: SEQ_CTRL_JC_EN (1010 = JC instead of NOP).
module seq_ctrl_dec
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W = 4
) (
    input  logic [OP_W-1:0] op,
    input  logic            c,
    output logic [3:0]      ld_n,
    output logic [1:0]      sel,
    output logic            is_out,
    output logic            is_halt
);

    logic    hi_zero;
    opcode_t op_e;

    // Opcodes with any nonzero upper bit are treated as NOP
    generate
        if (OP_W > 4) begin : g_hi
            assign hi_zero = (op[OP_W-1:4] == '0);
        end else begin : g_no_hi
            assign hi_zero = 1'b1;
        end
    endgenerate

    assign op_e = opcode_t'(op[3:0]);

    always_comb begin
        ld_n    = LOAD_NONE;
        sel     = SEL_ZERO;
        is_out  = 1'b0;
        is_halt = 1'b0;
        if (hi_zero) begin
            case (op_e)
                OP_MOV_A_IM: ld_n = LOAD_A;
                OP_MOV_B_IM: ld_n = LOAD_B;
                OP_MOV_AB:   begin ld_n = LOAD_A; sel = SEL_B; end
                OP_MOV_BA:   begin ld_n = LOAD_B; sel = SEL_A; end
                OP_ADD_A:    begin ld_n = LOAD_A; sel = SEL_A; end
                OP_ADD_B:    begin ld_n = LOAD_B; sel = SEL_B; end
                OP_IN_A:     begin ld_n = LOAD_A; sel = SEL_IN; end
                OP_IN_B:     begin ld_n = LOAD_B; sel = SEL_IN; end
                OP_OUT_IM:   begin ld_n = LOAD_OUT; is_out = 1'b1; end
                OP_OUT_B:    begin ld_n = LOAD_OUT; sel = SEL_B; is_out = 1'b1; end
                OP_JMP:      ld_n = LOAD_PC;
                OP_JNC:      if (!c) ld_n = LOAD_PC;
`ifdef SEQ_CTRL_JC_EN
                OP_JC:       if (c) ld_n = LOAD_PC;
`endif
                OP_HALT:     is_halt = 1'b1;
                default:     ;
            endcase
        end
    end

endmodule

// File: rtl/seq_ctrl_unit.sv
// seq_ctrl_unit: multi-cycle fetch/execute sequencer for a TD4-class datapath.
// Ports: clk, rst_n (async active-low); instr_valid/instr_ready/instr_op/c
//        instruction handshake; out_ready output-port ready; resume leaves HALTED;
//        sel ALU select, ld_n active-low load strobes, pc_inc PC increment,
//        halted in HALTED, err sticky OUT-timeout flag. All outputs registered.
// Optional feature macro: SEQ_CTRL_JC_EN (decoded in seq_ctrl_dec).
module seq_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W        = 4,
    parameter int unsigned OUT_TIMEOUT = 15,
    parameter int unsigned NLD         = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [OP_W-1:0] instr_op,
    input  logic            c,
    input  logic            out_ready,
    input  logic            resume,
    output logic [1:0]      sel,
    output logic [NLD-1:0]  ld_n,
    output logic            pc_inc,
    output logic            halted,
    output logic            err
);

    localparam int unsigned CNT_W = (OUT_TIMEOUT == 0) ? 1 : $clog2(OUT_TIMEOUT + 1);

    state_t          state;
    logic [OP_W-1:0] op_q;
    logic            c_q;
    logic [CNT_W-1:0] cnt;

    logic [OP_W-1:0] dec_op;
    logic            dec_c;
    logic [3:0]      dec_ld_n;
    logic [1:0]      dec_sel;
    logic            dec_is_out;
    logic            dec_is_halt;
    logic            handshake;
    logic [CNT_W:0]  cnt_inc;
    logic            expired;

    // Decode the incoming opcode in FETCH so strobes register on the handshake
    // edge; later states decode the latched opcode.
    assign dec_op    = (state == ST_FETCH) ? instr_op : op_q;
    assign dec_c     = (state == ST_FETCH) ? c : c_q;
    assign handshake = instr_valid && instr_ready;
    assign cnt_inc   = {1'b0, cnt} + (CNT_W+1)'(1);
    assign expired   = (OUT_TIMEOUT != 0) && (cnt_inc >= (CNT_W+1)'(OUT_TIMEOUT));

    seq_ctrl_dec #(.OP_W(OP_W)) u_dec (
        .op      (dec_op),
        .c       (dec_c),
        .ld_n    (dec_ld_n),
        .sel     (dec_sel),
        .is_out  (dec_is_out),
        .is_halt (dec_is_halt)
    );

    // Sequencer FSM with registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            op_q        <= '0;
            c_q         <= 1'b0;
            cnt         <= '0;
            instr_ready <= 1'b0;
            ld_n        <= NLD'(LOAD_NONE);
            sel         <= SEL_ZERO;
            pc_inc      <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    ld_n        <= NLD'(LOAD_NONE);
                    pc_inc      <= 1'b0;
                    instr_ready <= 1'b1;
                    if (handshake) begin
                        op_q        <= instr_op;
                        c_q         <= c;
                        instr_ready <= 1'b0;
                        sel         <= dec_sel;
                        if (dec_is_out && !out_ready) begin
                            state <= ST_OUT_WAIT;
                            cnt   <= '0;
                        end else begin
                            state  <= ST_EXEC;
                            ld_n   <= NLD'(dec_ld_n);
                            // bit3 high means no PC load, so the PC advances
                            pc_inc <= dec_ld_n[3];
                        end
                    end
                end
                ST_EXEC: begin
                    ld_n   <= NLD'(LOAD_NONE);
                    pc_inc <= 1'b0;
                    if (dec_is_halt) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end else begin
                        state       <= ST_FETCH;
                        instr_ready <= 1'b1;
                    end
                end
                ST_OUT_WAIT: begin
                    // A late out_ready beats an expiring counter
                    if (out_ready) begin
                        ld_n        <= NLD'(dec_ld_n);
                        sel         <= dec_sel;
                        pc_inc      <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_FETCH;
                        instr_ready <= 1'b1;
                    end else if (expired) begin
                        pc_inc      <= 1'b1;
                        err         <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_FETCH;
                        instr_ready <= 1'b1;
                    end else begin
                        cnt <= cnt_inc[CNT_W-1:0];
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        state       <= ST_FETCH;
                        halted      <= 1'b0;
                        instr_ready <= 1'b1;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_ctrl_unit.sv
// tb_seq_ctrl_unit: directed self-checking bench for seq_ctrl_unit.
module tb_seq_ctrl_unit;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic       c;
    logic       out_ready;
    logic       resume;
    logic [1:0] sel;
    logic [3:0] ld_n;
    logic       pc_inc;
    logic       halted;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    seq_ctrl_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .c           (c),
        .out_ready   (out_ready),
        .resume      (resume),
        .sel         (sel),
        .ld_n        (ld_n),
        .pc_inc      (pc_inc),
        .halted      (halted),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one opcode and return just after the handshake edge
    task automatic issue(input logic [3:0] op, input logic cv);
        for (int i = 0; i < 20 && !instr_ready; i++) tick();
        check("ready_before_issue", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr_op    = op;
        c           = cv;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [3:0] op, input logic cv,
                           input logic [3:0] exp_ld, input logic [1:0] exp_sel,
                           input logic exp_pc);
        issue(op, cv);
        check({tag, "_ld"}, 32'(ld_n), 32'(exp_ld));
        check({tag, "_sel"}, 32'(sel), 32'(exp_sel));
        check({tag, "_pc"}, 32'(pc_inc), 32'(exp_pc));
        tick();
        check({tag, "_ld_off"}, 32'(ld_n), 32'hF);
        check({tag, "_pc_off"}, 32'(pc_inc), 32'd0);
        check({tag, "_rdy"}, 32'(instr_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       jc_exp_pc;
        logic [3:0] jc_exp_ld;
`ifdef SEQ_CTRL_JC_EN
        jc_exp_ld = 4'b0111;
        jc_exp_pc = 1'b0;
`else
        jc_exp_ld = 4'b1111;
        jc_exp_pc = 1'b1;
`endif
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_op    = 4'h0;
        c           = 1'b0;
        out_ready   = 1'b1;
        resume      = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_ld", 32'(ld_n), 32'hF);
        check("rst_sel", 32'(sel), 32'h3);
        check("rst_pc", 32'(pc_inc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdy", 32'(instr_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_rdy", 32'(instr_ready), 32'd1);

        // Decode table, one strobe cycle each
        run_vec("mov_a_im", 4'b0011, 1'b0, 4'b1110, 2'b11, 1'b1);
        run_vec("mov_b_im", 4'b0111, 1'b0, 4'b1101, 2'b11, 1'b1);
        run_vec("mov_ab",   4'b0001, 1'b0, 4'b1110, 2'b01, 1'b1);
        run_vec("mov_ba",   4'b0100, 1'b0, 4'b1101, 2'b00, 1'b1);
        run_vec("add_a",    4'b0000, 1'b0, 4'b1110, 2'b00, 1'b1);
        run_vec("add_b",    4'b0101, 1'b0, 4'b1101, 2'b01, 1'b1);
        run_vec("in_a",     4'b0010, 1'b0, 4'b1110, 2'b10, 1'b1);
        run_vec("in_b",     4'b0110, 1'b0, 4'b1101, 2'b10, 1'b1);
        run_vec("out_im",   4'b1011, 1'b0, 4'b1011, 2'b11, 1'b1);
        run_vec("out_b",    4'b1001, 1'b0, 4'b1011, 2'b01, 1'b1);
        run_vec("jmp",      4'b1111, 1'b0, 4'b0111, 2'b11, 1'b0);
        run_vec("jnc_c0",   4'b1110, 1'b0, 4'b0111, 2'b11, 1'b0);
        run_vec("jnc_c1",   4'b1110, 1'b1, 4'b1111, 2'b11, 1'b1);
        run_vec("nop_1100", 4'b1100, 1'b0, 4'b1111, 2'b11, 1'b1);
        run_vec("jc_c0",    4'b1010, 1'b0, 4'b1111, 2'b11, 1'b1);

        // OUT B stalled for three cycles, then accepted
        out_ready = 1'b0;
        issue(4'b1001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("outb_wait_ld", 32'(ld_n), 32'hF);
            check("outb_wait_pc", 32'(pc_inc), 32'd0);
            check("outb_wait_rdy", 32'(instr_ready), 32'd0);
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        tick();
        check("outb_ld", 32'(ld_n), 32'hB);
        check("outb_sel", 32'(sel), 32'h1);
        check("outb_pc", 32'(pc_inc), 32'd1);
        check("outb_err", 32'(err), 32'd0);
        tick();
        check("outb_ld_off", 32'(ld_n), 32'hF);
        check("outb_pc_off", 32'(pc_inc), 32'd0);

        // OUT IM times out after 15 wait cycles
        out_ready = 1'b0;
        issue(4'b1011, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            check("to_wait_pc", 32'(pc_inc), 32'd0);
            check("to_wait_err", 32'(err), 32'd0);
            check("to_wait_ld", 32'(ld_n), 32'hF);
            tick();
        end
        check("to_pc", 32'(pc_inc), 32'd1);
        check("to_err", 32'(err), 32'd1);
        check("to_ld", 32'(ld_n), 32'hF);
        check("to_rdy", 32'(instr_ready), 32'd1);
        tick();
        check("to_pc_off", 32'(pc_inc), 32'd0);
        check("to_err_sticky", 32'(err), 32'd1);
        out_ready = 1'b1;
        run_vec("after_to", 4'b0111, 1'b0, 4'b1101, 2'b11, 1'b1);
        check("err_still", 32'(err), 32'd1);

        // resume outside HALTED has no effect
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume_fetch_halted", 32'(halted), 32'd0);
        check("resume_fetch_rdy", 32'(instr_ready), 32'd1);

        // HALT holds off fetch until resume
        issue(4'b1000, 1'b0);
        check("halt_exec_ld", 32'(ld_n), 32'hF);
        check("halt_exec_pc", 32'(pc_inc), 32'd1);
        check("halt_exec_halted", 32'(halted), 32'd0);
        instr_valid = 1'b1;
        instr_op    = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("halted", 32'(halted), 32'd1);
            check("halted_rdy", 32'(instr_ready), 32'd0);
            check("halted_ld", 32'(ld_n), 32'hF);
        end
        instr_valid = 1'b0;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume_rdy", 32'(instr_ready), 32'd1);
        check("resume_halted", 32'(halted), 32'd0);

        // Asynchronous reset while waiting on the output port
        out_ready = 1'b0;
        issue(4'b1001, 1'b0);
        tick();
        check("pre_rst_sel", 32'(sel), 32'h1);
        check("pre_rst_err", 32'(err), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ld", 32'(ld_n), 32'hF);
        check("arst_sel", 32'(sel), 32'h3);
        check("arst_err", 32'(err), 32'd0);
        check("arst_pc", 32'(pc_inc), 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("arst_fetch_rdy", 32'(instr_ready), 32'd1);
        run_vec("jc_c1", 4'b1010, 1'b1, jc_exp_ld, 2'b11, jc_exp_pc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_ctrl_unit.md
Name: seq_ctrl_unit

Overview:
- Multi-cycle successor to the combinational TD4-class instruction decoder.
- Sits between the instruction ROM/fetch path and the register file, output latch and PC.
- Sequences fetch/execute, handshakes with the instruction source and the output port, and drives registered select and load strobes.
- Adds a HALT instruction, an output-port stall with timeout, and a sticky error flag.

Parameters:
- OP_W, 4, opcode width; opcode values defined in ctrl_pkg, upper OP_W-4 bits must be zero.
- OUT_TIMEOUT, 15, max cycles waiting for out_ready before dropping an OUT; 0 = wait forever.
- NLD, 4, number of load strobes (A, B, OUT, PC), fixed at 4, kept for package consistency.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction source presents a valid opcode.
- instr_ready  out  1  unit accepts an opcode this cycle.
- instr_op  in  OP_W  opcode, sampled when instr_valid && instr_ready.
- c  in  1  carry flag, sampled together with instr_op.
- out_ready  in  1  output port can take a value.
- resume  in  1  one-cycle pulse that leaves HALTED.
- sel  out  2  ALU source select: 00=A, 01=B, 10=IN, 11=ZERO.
- ld_n  out  NLD  active-low one-hot load strobes: bit0=A, bit1=B, bit2=OUT, bit3=PC.
- pc_inc  out  1  PC increment strobe.
- halted  out  1  unit is in HALTED.
- err  out  1  sticky: an OUT timeout occurred.

Behaviour:
- Reset (async, rst_n=0):
  - State = FETCH.
  - ld_n=4'b1111, sel=2'b11, pc_inc=0, halted=0, err=0, instr_ready=0.
  - Timeout counter = 0.
- All outputs are registered. instr_ready=1 only in FETCH.
- States are FETCH, EXEC, OUT_WAIT, HALTED.
- FETCH:
  - Waits for instr_valid.
  - On a handshake: latch op and c, go to EXEC next cycle.
  - ld_n stays all-ones.
- EXEC (exactly one cycle):
  - ld_n and sel are driven per the decode table below.
  - pc_inc=1 unless the PC load is asserted.
  - Returns to FETCH.
  - Fetch-to-strobe latency is 1 cycle after the handshake; throughput is one instruction per 2 cycles.
- Decode table (op -> ld, sel):
  - 0011 MOV A,IM -> A, ZERO
  - 0111 MOV B,IM -> B, ZERO
  - 0001 MOV A,B -> A, B
  - 0100 MOV B,A -> B, A
  - 0000 ADD A,IM -> A, A
  - 0101 ADD B,IM -> B, B
  - 0010 IN A -> A, IN
  - 0110 IN B -> B, IN
  - 1011 OUT IM -> OUT, ZERO
  - 1001 OUT B -> OUT, B
  - 1111 JMP -> PC, ZERO
  - 1110 JNC -> PC, ZERO if latched c==0, else no load
  - 1000 HALT -> no load
  - Any other op is a NOP: no load, sel=ZERO, pc_inc=1.
- OUT with out_ready=0 at the EXEC cycle:
  - Go to OUT_WAIT; ld_n stays all-ones, sel is held, pc_inc=0.
  - Each cycle in OUT_WAIT, the counter increments.
  - On out_ready=1: the OUT strobe and pc_inc pulse for one cycle, counter clears, go to FETCH.
  - If OUT_TIMEOUT!=0 and the counter reaches OUT_TIMEOUT with out_ready still 0: drop the write, pulse pc_inc, set err, go to FETCH.
  - If out_ready rises in the same cycle the counter expires, the write wins.
- HALT:
  - EXEC asserts no load, pc_inc=1, then enters HALTED; halted=1 from the next cycle.
  - instr_ready stays 0 while HALTED.
  - resume=1 in HALTED -> FETCH next cycle; halted=0.
  - resume is ignored in every other state.
- err clears only on reset.
- Reset mid-operation: any strobe is cancelled immediately (asynchronously). There is no partial write; the instruction is lost.

Optional Feature:
- Macro: SEQ_CTRL_JC_EN.
- Defined: opcode 1010 = JC, which loads PC with sel=ZERO when latched c==1, otherwise pc_inc.
- Undefined: 1010 decodes as NOP.

Decomposition:
- ctrl_pkg holds:
  - opcode enum;
  - LOAD_A/B/OUT/PC/NONE active-low patterns;
  - select enum (SEL_A/B/IN/ZERO);
  - state enum.
- One sub-module, seq_ctrl_dec: the combinational op+c -> {ld_n, sel, is_out, is_halt} lookup, instantiated once.
- FSM, counter and output registers stay in seq_ctrl_unit.

Test Plan:
- Reset release, then op=0011 valid:
  - ld_n=1110 and sel=11 for exactly one cycle, one cycle after the handshake;
  - pc_inc=1 in that cycle.
- JNC (1110):
  - with c=0 -> ld_n=0111, pc_inc=0;
  - with c=1 -> ld_n=1111, pc_inc=1.
- OUT B (1001) with out_ready=0 for 3 cycles, then 1:
  - ld_n stays 1111 for 3 cycles;
  - then ld_n=1011, sel=01 for one cycle;
  - err=0.
- OUT IM with out_ready held 0, OUT_TIMEOUT=15:
  - after 15 OUT_WAIT cycles, pc_inc pulses and err=1 (sticky);
  - the next instruction is accepted.
- HALT (1000):
  - halted=1 and instr_ready=0 for 10 cycles despite instr_valid=1;
  - a resume pulse -> instr_ready=1 next cycle.
- rst_n low during OUT_WAIT:
  - ld_n=1111, sel=11, err=0 immediately (asynchronously);
  - FETCH after release;
  - op=1010 behaves as NOP unless SEQ_CTRL_JC_EN is defined.
